// File: rtl/adc_pkt_pkg.sv
// Shared definitions for the ADC capture packet receiver.
//   HDR_MARKER   : value of header bits [17:16]
//   ST_*         : FSM state encodings (state_t)
//   ERR_*        : bit positions inside err_flags {seq, ovf, idle, long, short}
//   DW_DEFAULT   : default pad data width
package adc_pkt_pkg;

    localparam int unsigned DW_DEFAULT = 18;

    localparam logic [1:0] HDR_MARKER = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_DROP = 3'd3;
    localparam state_t ST_GAP  = 3'd4;

    localparam int unsigned ERR_W     = 5;
    localparam int unsigned ERR_SHORT = 0;
    localparam int unsigned ERR_LONG  = 1;
    localparam int unsigned ERR_IDLE  = 2;
    localparam int unsigned ERR_OVF   = 3;
    localparam int unsigned ERR_SEQ   = 4;

endpackage

// File: rtl/adc_pkt_rx_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i         : write request; taken only when wr_ready_o is high
//   wr_data_i       : write word
//   wr_ready_o      : space available this cycle (not full, or a read frees a slot)
//   rd_en_i         : pop the head word (ignored when empty)
//   rd_data_o       : head word, forced to zero while empty
//   full_o, empty_o : occupancy flags
module adc_pkt_rx_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_ready_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_wr, do_rd;

    always_comb begin
        empty_o    = (wptr_q == rptr_q);
        full_o     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_rd      = rd_en_i && !empty_o;
        // A read in the same cycle frees the slot, so a full FIFO can still accept.
        wr_ready_o = !full_o || do_rd;
        do_wr      = wr_en_i && wr_ready_o;
        wptr_d     = wptr_q + {{AW{1'b0}}, do_wr};
        rptr_d     = rptr_q + {{AW{1'b0}}, do_rd};
        rd_data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/adc_pkt_rx.sv
// Receive side of the ADC capture packet link (CLK_RD domain).
// Registers the pad bus, delineates header + payload packets, checks framing against
// cfg_data_len / cfg_idle_len, buffers payload in a FWFT FIFO toward a ready/valid sink,
// and keeps sticky error flags plus saturating packet / error counters.
// Optional: define ADC_PKT_RX_SEQ_CHECK_EN to enable header sequence-number checking.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   adc_data, adc_data_valid  : pad bus and its level qualifier
//   cfg_data_len              : payload words per packet minus 1 (latched per header)
//   cfg_idle_len              : minimum low-valid cycles between packets
//   clr_stat                  : pulse, clears counters, flags and sequence history
//   m_data/m_sop/m_eop/m_valid/m_ready : payload stream out
//   pkt_cnt, err_cnt          : good / errored packet counters (saturating)
//   err_flags                 : sticky {seq, ovf, idle, long, short}
//   rx_busy                   : FSM inside a packet (DATA or DROP)
module adc_pkt_rx
    import adc_pkt_pkg::*;
#(
    parameter int unsigned DW         = DW_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    adc_data,
    input  logic             adc_data_valid,
    input  logic [7:0]       cfg_data_len,
    input  logic [7:0]       cfg_idle_len,
    input  logic             clr_stat,
    output logic [DW-1:0]    m_data,
    output logic             m_sop,
    output logic             m_eop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ERR_W-1:0] err_flags,
    output logic             rx_busy
);

    localparam int unsigned FW = DW + 2;

    // Pad capture stage
    logic [DW-1:0] in_data_q;
    logic          in_valid_q;
    logic          seen_low_q, seen_low_d;

    // Framing FSM
    state_t     state_q, state_d, st_eval;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] len_q, len_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       after_eop_q, after_eop_d;

    // Statistics
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] flags_q, flags_d;
    logic [ERR_W-1:0] err_set_fsm, err_set;
    logic             err_inc_fsm, err_inc, pkt_inc, hdr_ok, seq_err;

    // FIFO interface
    logic          fifo_wr, fifo_space, fifo_rd, fifo_full, fifo_empty;
    logic [DW-1:0] wr_word;
    logic          wr_sop, wr_eop;
    logic [FW-1:0] fifo_rd_data;

    always_comb begin
        // Pad must be seen low once after reset before a rising valid counts as a header.
        seen_low_d = seen_low_q | ~adc_data_valid;
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        len_d       = len_q;
        gap_cnt_d   = gap_cnt_q;
        after_eop_d = after_eop_q;
        fifo_wr     = 1'b0;
        wr_word     = in_data_q;
        wr_sop      = 1'b0;
        wr_eop      = 1'b0;
        err_set_fsm = '0;
        err_inc_fsm = 1'b0;
        pkt_inc     = 1'b0;
        hdr_ok      = 1'b0;

        // The header is evaluated in the cycle it is presented, so HDR is never registered.
        st_eval = state_q;
        if (in_valid_q && ((state_q == ST_IDLE && seen_low_q) ||
                           (state_q == ST_GAP && !after_eop_q))) begin
            st_eval = ST_HDR;
        end

        case (st_eval)
            ST_IDLE: begin
                // Valid already high out of reset: mid-packet, discard it.
                if (in_valid_q) begin
                    state_d = ST_DROP;
                end
            end
            ST_HDR: begin
                if (state_q == ST_GAP && gap_cnt_q < cfg_idle_len) begin
                    err_set_fsm[ERR_IDLE] = 1'b1;
                    err_inc_fsm           = 1'b1;
                end
                if (in_data_q[DW-1 -: 2] == HDR_MARKER) begin
                    hdr_ok  = 1'b1;
                    len_d   = cfg_data_len;
                    wcnt_d  = 8'd0;
                    state_d = ST_DATA;
                end else begin
                    err_set_fsm[ERR_SHORT] = 1'b1;
                    err_inc_fsm            = 1'b1;
                    state_d                = ST_DROP;
                end
            end
            ST_DATA: begin
                wr_sop = (wcnt_q == 8'd0);
                if (in_valid_q) begin
                    wr_eop = (wcnt_q == len_q);
                    if (fifo_space) begin
                        fifo_wr = 1'b1;
                        if (wr_eop) begin
                            pkt_inc     = 1'b1;
                            state_d     = ST_GAP;
                            gap_cnt_d   = 8'd0;
                            after_eop_d = 1'b1;
                        end else begin
                            wcnt_d = wcnt_q + 8'd1;
                        end
                    end else begin
                        err_set_fsm[ERR_OVF] = 1'b1;
                        err_inc_fsm          = 1'b1;
                        state_d              = ST_DROP;
                    end
                end else begin
                    // Truncated: close the packet with a zero word when there is room.
                    err_set_fsm[ERR_SHORT] = 1'b1;
                    err_inc_fsm            = 1'b1;
                    wr_word                = '0;
                    wr_eop                 = 1'b1;
                    fifo_wr                = fifo_space;
                    state_d                = ST_GAP;
                    gap_cnt_d              = 8'd0;
                    after_eop_d            = 1'b0;
                end
            end
            ST_DROP: begin
                if (!in_valid_q) begin
                    state_d     = ST_GAP;
                    gap_cnt_d   = 8'd0;
                    after_eop_d = 1'b0;
                end
            end
            ST_GAP: begin
                // Only reached with valid high when it directly follows eop.
                after_eop_d = 1'b0;
                if (in_valid_q) begin
                    err_set_fsm[ERR_LONG] = 1'b1;
                    err_inc_fsm           = 1'b1;
                    state_d               = ST_DROP;
                end else if (gap_cnt_q != 8'hff) begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ADC_PKT_RX_SEQ_CHECK_EN
    logic [15:0] seq_q, seq_d;
    logic        seq_vld_q, seq_vld_d;

    always_comb begin
        seq_d     = seq_q;
        seq_vld_d = seq_vld_q;
        seq_err   = 1'b0;
        if (hdr_ok) begin
            seq_err   = seq_vld_q && (in_data_q[15:0] != seq_q + 16'd1);
            seq_d     = in_data_q[15:0];
            seq_vld_d = 1'b1;
        end
        // Next header after a clear starts a fresh sequence.
        if (clr_stat) begin
            seq_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q     <= '0;
            seq_vld_q <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            seq_vld_q <= seq_vld_d;
        end
    end
`else
    logic unused_hdr_ok;
    assign unused_hdr_ok = hdr_ok;
    assign seq_err       = 1'b0;
`endif

    always_comb begin
        err_set = err_set_fsm;
        if (seq_err) begin
            err_set[ERR_SEQ] = 1'b1;
        end
        err_inc = err_inc_fsm | seq_err;

        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        flags_d   = flags_q | err_set;
        if (pkt_inc && pkt_cnt_q != '1) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
        if (err_inc && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (clr_stat) begin
            pkt_cnt_d = '0;
            err_cnt_d = '0;
            flags_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_data_q   <= '0;
            in_valid_q  <= 1'b0;
            seen_low_q  <= 1'b0;
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            len_q       <= '0;
            gap_cnt_q   <= '0;
            after_eop_q <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            flags_q     <= '0;
        end else begin
            in_data_q   <= adc_data;
            in_valid_q  <= adc_data_valid;
            seen_low_q  <= seen_low_d;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            len_q       <= len_d;
            gap_cnt_q   <= gap_cnt_d;
            after_eop_q <= after_eop_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            flags_q     <= flags_d;
        end
    end

    assign fifo_rd = m_valid && m_ready;

    adc_pkt_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (fifo_wr),
        .wr_data_i  ({wr_sop, wr_eop, wr_word}),
        .wr_ready_o (fifo_space),
        .rd_en_i    (fifo_rd),
        .rd_data_o  (fifo_rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

    assign {m_sop, m_eop, m_data} = fifo_rd_data;
    assign m_valid   = !fifo_empty;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_flags = flags_q;
    assign rx_busy   = (state_q == ST_DATA) || (state_q == ST_DROP);

endmodule

// File: tb/tb_adc_pkt_rx.sv
// Scoreboard bench for adc_pkt_rx: stimulus pushes expected {sop, eop, data} words,
// a monitor pops and compares on every accepted output word.
module tb_adc_pkt_rx;

    localparam logic [4:0] F_NONE  = 5'b00000;
    localparam logic [4:0] F_SHORT = 5'b00001;
    localparam logic [4:0] F_IDLE  = 5'b00100;
    localparam logic [4:0] F_OVF   = 5'b01000;
    localparam logic [4:0] F_SEQ   = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] adc_data;
    logic        adc_data_valid;
    logic [7:0]  cfg_data_len;
    logic [7:0]  cfg_idle_len;
    logic        clr_stat;
    logic [17:0] m_data;
    logic        m_sop, m_eop, m_valid;
    logic        m_ready;
    logic [15:0] pkt_cnt, err_cnt;
    logic [4:0]  err_flags;
    logic        rx_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] exp_q [$];

    adc_pkt_rx dut (
        .clk            (clk),
        .rst            (rst),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .cfg_data_len   (cfg_data_len),
        .cfg_idle_len   (cfg_idle_len),
        .clr_stat       (clr_stat),
        .m_data         (m_data),
        .m_sop          (m_sop),
        .m_eop          (m_eop),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .pkt_cnt        (pkt_cnt),
        .err_cnt        (err_cnt),
        .err_flags      (err_flags),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive pads for one cycle; returns 1 time unit after the sampling edge.
    task automatic put(input logic v, input logic [17:0] d);
        adc_data_valid = v;
        adc_data       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 18'd0);
    endtask

    task automatic send_pkt(input logic [15:0] seq, input int n, input logic [15:0] base,
                            input bit push);
        put(1'b1, {2'b11, seq});
        for (int i = 0; i < n; i++) begin
            if (push) exp_q.push_back({(i == 0), (i == n - 1), 2'b00, base + 16'(i)});
            put(1'b1, {2'b00, base + 16'(i)});
        end
    endtask

    task automatic clr_pulse();
        clr_stat = 1'b1;
        put(1'b0, 18'd0);
        clr_stat = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_stats(input string name, input int pc, input int ec, input logic [4:0] fl);
        chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(pc));
        chk({name, "_err_cnt"}, 64'(err_cnt), 64'(ec));
        chk({name, "_err_flags"}, 64'(err_flags), 64'(fl));
    endtask

    // Monitor: compare every accepted output word against the scoreboard head.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_word: got sop=%b eop=%b data=%h, expected no word",
                             m_sop, m_eop, m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", 64'({m_sop, m_eop, m_data}), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        adc_data       = '0;
        adc_data_valid = 1'b0;
        cfg_data_len   = 8'd0;
        cfg_idle_len   = 8'd15;
        clr_stat       = 1'b0;
        m_ready        = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("reset_out", 64'({m_valid, m_sop, m_eop, m_data, rx_busy}), 64'd0);
        chk_stats("reset", 0, 0, F_NONE);
        idle(3);

        // Nominal: three single-word packets, legal gaps
        send_pkt(16'd0, 1, 16'h0100, 1'b1);
        idle(15);
        send_pkt(16'd1, 1, 16'h0200, 1'b1);
        idle(15);
        send_pkt(16'd2, 1, 16'h0300, 1'b1);
        idle(15);
        drain("nominal_drain");
        chk_stats("nominal", 3, 0, F_NONE);

        // Short idle gap: 10 < 15, next packet still delivered
        send_pkt(16'd3, 1, 16'h0400, 1'b1);
        idle(10);
        send_pkt(16'd4, 1, 16'h0500, 1'b1);
        idle(15);
        drain("idle_drain");
        chk_stats("idle", 5, 1, F_IDLE);
        clr_pulse();
        chk_stats("clr1", 0, 0, F_NONE);

        // Truncated: 8 words expected, 4 sent, forced zero eop
        cfg_data_len = 8'd7;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 1'b0, 2'b00, 16'h3000 + 16'(i)});
        exp_q.push_back(20'h40000);
        send_pkt(16'd10, 4, 16'h3000, 1'b0);
        idle(20);
        drain("short_drain");
        chk_stats("short", 0, 1, F_SHORT);
        clr_pulse();

        // Overflow: 32 words into a stalled 16-deep buffer
        cfg_data_len = 8'd31;
        m_ready      = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 0), 1'b0, 2'b00, 16'h4000 + 16'(i)});
        send_pkt(16'd11, 32, 16'h4000, 1'b0);
        idle(20);
        chk("stall_hold", 64'({m_valid, m_sop, m_eop, m_data}), 64'({1'b1, exp_q[0]}));
        chk_stats("ovf", 0, 1, F_OVF);
        idle(3);
        chk("stall_hold2", 64'({m_valid, m_sop, m_eop, m_data}), 64'({1'b1, exp_q[0]}));
        m_ready = 1'b1;
        drain("ovf_drain");
        idle(3);
        chk("ovf_empty", 64'(m_valid), 64'd0);
        clr_pulse();
        idle(20);

        // Sequence gap 5, 6, 8
        cfg_data_len = 8'd0;
        send_pkt(16'd5, 1, 16'h0600, 1'b1);
        idle(15);
        send_pkt(16'd6, 1, 16'h0700, 1'b1);
        idle(15);
        send_pkt(16'd8, 1, 16'h0800, 1'b1);
        idle(15);
        drain("seq_drain");
`ifdef ADC_PKT_RX_SEQ_CHECK_EN
        chk_stats("seq", 3, 1, F_SEQ);
`else
        chk_stats("seq", 3, 0, F_NONE);
`endif

        // Reset mid-packet with valid held high
        cfg_data_len = 8'd7;
        m_ready      = 1'b0;
        put(1'b1, {2'b11, 16'd20});
        put(1'b1, 18'h05000);
        put(1'b1, 18'h05001);
        put(1'b1, 18'h05002);
        rst = 1'b1;
        put(1'b1, 18'h05003);
        rst = 1'b0;
        chk("rst_mid_out", 64'({m_valid, m_sop, m_eop, m_data, rx_busy}), 64'd0);
        chk_stats("rst_mid", 0, 0, F_NONE);
        put(1'b1, 18'h05004);
        put(1'b1, 18'h05005);
        chk("rst_mid_drop", 64'({rx_busy, m_valid}), 64'({1'b1, 1'b0}));
        idle(20);
        m_ready = 1'b1;
        send_pkt(16'd21, 8, 16'h6000, 1'b1);
        idle(20);
        drain("rst_drain");
        chk_stats("after_rst", 1, 0, F_NONE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
